// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
// The arbiter takes the slave view; the requesters and RAM together take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata, busy,
        output mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata, busy,
        input  mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port between the CPU data path (port 0, fixed priority)
// and a secondary reader (port 1), forcing port 1 after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     starve, starve_nxt;
    logic [LW-1:0]     lat_cnt, lat_cnt_nxt;
    logic              owner;
    logic              we_q;
    logic              grant;
    logic              grant_port;
    logic              capture;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        if (v >= SW'(MAX_WAIT)) return SW'(MAX_WAIT);
        return v + SW'(1);
    endfunction

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve;
        lat_cnt_nxt  = lat_cnt;
        grant        = 1'b0;
        grant_port   = 1'b0;
        capture      = 1'b0;
        bus.ack0     = 1'b0;
        bus.ack1     = 1'b0;
        bus.mem_wren = 1'b0;
        bus.busy     = (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    grant = 1'b1;
                    if (starve >= SW'(MAX_WAIT)) begin
                        grant_port = 1'b1;
                        starve_nxt = '0;
                    end else begin
                        starve_nxt = sat_inc(starve);
                    end
                end else if (bus.req1) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                    starve_nxt = '0;
                end else begin
                    // Port 1 not waiting, so any accumulated loss count is void.
                    grant      = bus.req0;
                    starve_nxt = '0;
                end
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_wren = we_q;
                if (we_q) begin
                    state_nxt = ACK;
                end else begin
                    lat_cnt_nxt = LW'(RD_LAT - 1);
                    state_nxt   = RDWAIT;
                end
            end
            RDWAIT: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    lat_cnt_nxt = lat_cnt - LW'(1);
                end
            end
            ACK: begin
                bus.ack0  = ~owner;
                bus.ack1  = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            starve  <= '0;
            lat_cnt <= '0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            starve  <= starve_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (grant) begin
                owner <= grant_port;
                we_q  <= grant_port ? bus.we1 : bus.we0;
            end
        end
    end

    // Memory-facing registers: address and write data are latched once at grant
    // and held stable until the next grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            if (grant) begin
                mem_addr_q  <= grant_port ? bus.addr1  : bus.addr0;
                mem_wdata_q <= grant_port ? bus.wdata1 : bus.wdata0;
            end
            if (capture) rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, arbitration/latency reference model with
// scoreboard queues, directed scenarios and randomized two-requester traffic.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;

    typedef struct {
        int          port;
        int          ack_edge;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          at;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   ack_log[$];

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // RAM model: RD_LAT registered stages between address and read data.
    logic [15:0] mem [0:65535];
    logic [15:0] rd_pipe [0:RD_LAT-1];
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
        mem[16'h0020] <= 16'h1234;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        forever begin
            @(posedge clk);
            if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
            rd_pipe[0] <= mem[bus.mem_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Reference model: decides each grant from the arbitration rules and predicts
    // the write strobe and ack edges plus the rdata seen at each ack.
    logic [15:0] ref_mem [0:65535];
    initial begin
        int          starve_m;
        int          free_edge;
        int          p;
        logic        we;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] last_rd;
        exp_t        e;
        starve_m  = 0;
        free_edge = 0;
        last_rd   = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        ref_mem[16'h0020] = 16'h1234;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!reset) begin
                exp_q.delete();
                wr_q.delete();
                starve_m  = 0;
                last_rd   = '0;
                free_edge = edge_n + 1;
            end else if (edge_n >= free_edge) begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1) begin
                        if (starve_m >= MAX_WAIT) begin
                            p = 1; starve_m = 0;
                        end else begin
                            p = 0; starve_m = (starve_m + 1 > MAX_WAIT) ? MAX_WAIT : starve_m + 1;
                        end
                    end else if (bus.req1) begin
                        p = 1; starve_m = 0;
                    end else begin
                        p = 0; starve_m = 0;
                    end
                    we = (p == 1) ? bus.we1 : bus.we0;
                    a  = (p == 1) ? bus.addr1 : bus.addr0;
                    wd = (p == 1) ? bus.wdata1 : bus.wdata0;
                    e.port     = p;
                    e.ack_edge = edge_n + 1 + (we ? 0 : RD_LAT);
                    if (we) begin
                        ref_mem[a] = wd;
                        wr_q.push_back('{at: edge_n, addr: a, data: wd});
                    end else begin
                        last_rd = ref_mem[a];
                    end
                    e.data = last_rd;
                    exp_q.push_back(e);
                    free_edge = e.ack_edge + 2;
                end else begin
                    starve_m = 0;
                end
            end
        end
    end

    // Monitor: pops predictions whenever the DUT acks or strobes a write.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
                ack_log.push_back(bus.ack1 ? 1 : 0);
                chk("ack_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'(bus.ack1), 32'(e.port));
                    chk("ack_cycle", 32'(edge_n), 32'(e.ack_edge));
                    chk("ack_rdata", 32'(bus.rdata), 32'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].ack_edge < edge_n) begin
                chk("ack_missing", 32'(bus.ack0 | bus.ack1), 32'd1);
                void'(exp_q.pop_front());
            end
            if (bus.mem_wren) begin
                chk("wren_pending", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    chk("wr_cycle", 32'(edge_n), 32'(w.at));
                    chk("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                end
            end else if (wr_q.size() > 0 && wr_q[0].at < edge_n) begin
                chk("wren_missing", 32'(bus.mem_wren), 32'd1);
                void'(wr_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_ack(input int p, input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            tick(1);
            if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) got = 1'b1;
        end
        if (!got) chk($sformatf("ack%0d_timeout", p), 32'(got), 32'd1);
    endtask

    task automatic wait_log(input int n, input int limit);
        int i;
        i = 0;
        while (ack_log.size() < n && i < limit) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("ack_log_timeout", 32'(ack_log.size() >= n), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_ack0"},  32'(bus.ack0), 32'd0);
        chk({tag, "_ack1"},  32'(bus.ack1), 32'd0);
        chk({tag, "_wren"},  32'(bus.mem_wren), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mwdat"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    endtask

    task automatic rand_port(input int p, input int n);
        bit          got;
        logic        we;
        logic [15:0] a;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 15));
            drive(p, 1'b1, we, a, 16'($urandom));
            wait_ack(p, 300, got);
            if ($urandom_range(0, 2) != 0) begin
                drive(p, 1'b0, 1'b0, '0, '0);
                tick($urandom_range(0, 3));
            end
        end
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        bit got;
        int base;
        int first_p1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b1;
        tick(1);

        // Single write on port 0.
        drive(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick(1);
        chk("w_wren", 32'(bus.mem_wren), 32'd1);
        chk("w_maddr", 32'(bus.mem_addr), 32'h0010);
        chk("w_mwdata", 32'(bus.mem_wdata), 32'hBEEF);
        tick(1);
        chk("w_ack0", 32'(bus.ack0), 32'd1);
        chk("w_ack1", 32'(bus.ack1), 32'd0);
        chk("w_wren_off", 32'(bus.mem_wren), 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick(1);

        // Single read on port 1.
        drive(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("r_quiet", {30'd0, bus.mem_wren, bus.ack1}, 32'd0);
        end
        tick(1);
        chk("r_ack1", 32'(bus.ack1), 32'd1);
        chk("r_rdata", 32'(bus.rdata), 32'h1234);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick(2);

        // Request dropped during ISSUE still completes exactly once.
        base = ack_log.size();
        drive(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        tick(1);
        drive(0, 1'b0, 1'b0, '0, '0);
        wait_ack(0, 20, got);
        chk("drop_rdata", 32'(bus.rdata), 32'(init_word(16'h0030)));
        tick(10);
        chk("drop_single_ack", 32'(ack_log.size() - base), 32'd1);
        chk("drop_idle", 32'(bus.busy), 32'd0);

        // Continuous contention: MAX_WAIT port-0 grants, then one port-1 grant.
        do_reset();
        ack_log.delete();
        drive(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0041, 16'h0000);
        wait_log(2 * (MAX_WAIT + 1), 400);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2 * (MAX_WAIT + 1) && i < ack_log.size(); i++)
            chk($sformatf("contend_%0d", i), 32'(ack_log[i]),
                32'((i % (MAX_WAIT + 1) == MAX_WAIT) ? 1 : 0));
        tick(8);

        // req1 dropped in IDLE clears the loss count.
        do_reset();
        ack_log.delete();
        drive(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0051, 16'h0000);
        wait_log(3, 200);
        drive(1, 1'b0, 1'b0, '0, '0);
        wait_log(4, 200);
        drive(1, 1'b1, 1'b0, 16'h0051, 16'h0000);
        wait_log(4 + MAX_WAIT + 1, 400);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        first_p1 = -1;
        for (int i = 0; i < ack_log.size(); i++)
            if (first_p1 < 0 && ack_log[i] == 1) first_p1 = i;
        chk("starve_clear_first_p1", 32'(first_p1), 32'(4 + MAX_WAIT));
        tick(8);

        // Reset during RDWAIT abandons the read.
        drive(0, 1'b1, 1'b0, 16'h0060, 16'h0000);
        tick(2);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        tick(1);
        check_outputs_zero("midreset");
        reset = 1'b1;
        base = ack_log.size();
        tick(6);
        chk("midreset_no_ack", 32'(ack_log.size() - base), 32'd0);
        drive(0, 1'b1, 1'b0, 16'h0061, 16'h0000);
        wait_ack(0, 20, got);
        chk("post_reset_rdata", 32'(bus.rdata), 32'(init_word(16'h0061)));
        drive(0, 1'b0, 1'b0, '0, '0);
        tick(4);

        // Randomized traffic from both requesters on a shared address window.
        fork
            rand_port(0, 120);
            rand_port(1, 120);
        join
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
        chk("drain", 32'(exp_q.size()), 32'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
